// File: rtl/m_imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (header N, 4N payload
// bytes LSB first, XOR checksum), writes 32-bit words into imem, and gates the CPU.
module m_imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_in_valid,
    input  logic [7:0]        w_in_data,
    output logic              w_in_ready,
    output logic              w_imem_we,
    output logic [ADDR_W-1:0] w_imem_addr,
    output logic [31:0]       w_imem_data,
    output logic              w_cpu_hold,
    output logic              w_done,
    output logic              w_err,
    output logic [ADDR_W:0]   w_words
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] ONE_W = (ADDR_W+1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;

    logic              hdr_ok;
    logic              last_word;
    logic [31:0]       word_d;

    always_comb begin
        hdr_ok    = (w_in_data != 8'd0) && (32'(w_in_data) <= 32'(DEPTH));
        last_word = (word_idx_q + ONE_W) == n_q;
        // The first three bytes shift in from the top, so the 4th byte completes the word.
        word_d    = {w_in_data, asm_q};
    end

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking assignments would let later statements see this cycle's updates.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (w_in_valid) begin
                unique case (state_q)
                    S_IDLE, S_DONE, S_ERR: begin
                        done_q     <= 1'b0;
                        hold_q     <= 1'b1;
                        words_q    <= '0;
                        n_q        <= (ADDR_W+1)'(w_in_data);
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        xor_q      <= '0;
                        if (hdr_ok) begin
                            state_q <= S_LOAD;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        xor_q      <= xor_q ^ w_in_data;
                        asm_q      <= {w_in_data, asm_q[23:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= word_idx_q[ADDR_W-1:0];
                            data_q     <= word_d;
                            words_q    <= words_q + ONE_W;
                            word_idx_q <= word_idx_q + ONE_W;
                            if (last_word) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_in_data == xor_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            hold_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign w_in_ready  = ~w_rst;
    assign w_imem_we   = we_q;
    assign w_imem_addr = addr_q;
    assign w_imem_data = data_q;
    assign w_cpu_hold  = hold_q;
    assign w_done      = done_q;
    assign w_err       = err_q;
    assign w_words     = words_q;

endmodule
